// File: rtl/led_blink_arbiter_pkg.sv
// ============================================================================
// Module   : led_blink_arbiter_pkg
// Purpose  : Shared state encoding and field widths for the LED blink arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_blink_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam int GAP_TICKS = 2;
    localparam int COUNT_W   = 4;
    localparam int LEN_W     = 3;

endpackage

`default_nettype wire

// File: rtl/led_blink_arbiter_tick.sv
// ============================================================================
// Module   : led_tick_gen
// Purpose  : Free-running prescaler emitting a one-cycle tick every TICK_DIV
//            clocks; clr restarts the count so a phase begins on a boundary.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_tick_gen #(
    parameter int TICK_DIV = 600000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_blink_arbiter.sv
// ============================================================================
// Module   : led_blink_arbiter
// Purpose  : Round-robin arbiter granting one requester at a time the LED for
//            a blink sequence (ON/OFF pairs) followed by a fixed dark gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_blink_arbiter
    import led_blink_arbiter_pkg::*;
#(
    parameter int TICK_DIV = 600000,
    parameter int NUM_REQ  = 3
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [COUNT_W*NUM_REQ-1:0]   blink_count,
    input  logic [LEN_W*NUM_REQ-1:0]     blink_len,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy,
    output logic                         led
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   win_q,   win_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;
    logic [COUNT_W-1:0] cnt_q,   cnt_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic [LEN_W-1:0]   phase_q, phase_d;
    logic               abort_q, abort_d;

    logic               clr;
    logic               tick;
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [COUNT_W-1:0] pick_cnt;
    logic [LEN_W-1:0]   pick_len;
    logic [LEN_W-1:0]   phase_len;
    logic               phase_end;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clr),
        .tick   (tick)
    );

    // Descending scan so the lowest offset from ptr is the last (winning) write.
    always_comb begin : p_pick
        int unsigned k;
        k          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = int'(ptr_q) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (req[k]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(k);
            end
        end
    end

    always_comb begin
        pick_cnt = blink_count[int'(pick_idx)*COUNT_W +: COUNT_W];
        pick_len = blink_len[int'(pick_idx)*LEN_W +: LEN_W];
        if (pick_cnt == '0) pick_cnt = COUNT_W'(1);
        if (pick_len == '0) pick_len = LEN_W'(1);
    end

    assign phase_len = (state_q == ST_GAP) ? LEN_W'(GAP_TICKS) : len_q;
    assign phase_end = tick && (phase_q == (phase_len - LEN_W'(1)));

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        abort_d = abort_q;
        phase_d = tick ? (phase_q + LEN_W'(1)) : phase_q;
        clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_ON;
                    win_d   = pick_idx;
                    cnt_d   = pick_cnt;
                    len_d   = pick_len;
                    abort_d = 1'b0;
                end
            end
            ST_ON, ST_OFF: begin
                if (!req[win_q]) begin
                    state_d = ST_GAP;
                    abort_d = 1'b1;
                end else if (phase_end) begin
                    if (state_q == ST_ON) begin
                        state_d = ST_OFF;
                    end else if (cnt_q == COUNT_W'(1)) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_ON;
                        cnt_d   = cnt_q - COUNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (phase_end) begin
                    state_d = ST_IDLE;
                    ptr_d   = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : (win_q + PTR_W'(1));
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every state entry restarts both the prescaler and the phase tick count.
        if (state_d != state_q) begin
            clr     = 1'b1;
            phase_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            phase_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            phase_q <= phase_d;
            abort_q <= abort_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign led  = (state_q == ST_ON);
    assign gnt  = busy ? (NUM_REQ'(1) << win_q) : '0;
    assign done = (state_q == ST_GAP && phase_end && !abort_q) ? gnt : '0;

endmodule

`default_nettype wire

// File: tb/tb_led_blink_arbiter.sv
// ============================================================================
// Module   : tb_led_blink_arbiter
// Purpose  : Self-checking bench; a schedule-based reference model predicts
//            led/gnt/done/busy every cycle for directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_blink_arbiter;

    localparam int TD  = 4;
    localparam int NR  = 3;
    localparam int GAP = 2;

    logic            clk;
    logic            resetn;
    logic [NR-1:0]   req;
    logic [4*NR-1:0] blink_count;
    logic [3*NR-1:0] blink_len;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   done;
    logic            busy;
    logic            led;

    int n_total;
    int n_bad;

    // Reference model: a pending per-cycle schedule of expected led/done values.
    bit m_active;
    int m_win;
    int m_ptr;
    int blink_left;
    bit sched_led[$];
    bit sched_done[$];

    led_blink_arbiter #(
        .TICK_DIV (TD),
        .NUM_REQ  (NR)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .blink_count (blink_count),
        .blink_len   (blink_len),
        .gnt         (gnt),
        .done        (done),
        .busy        (busy),
        .led         (led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_ptr      = 0;
        m_win      = 0;
        blink_left = 0;
        sched_led.delete();
        sched_done.delete();
    endtask

    task automatic check_outputs(input string tag);
        logic [NR-1:0] eg;
        eg = m_active ? NR'(1 << m_win) : '0;
        chk({tag, ".led"},  32'(led),  m_active ? 32'(sched_led[0]) : 32'd0);
        chk({tag, ".gnt"},  32'(gnt),  32'(eg));
        chk({tag, ".done"}, 32'(done), (m_active && sched_done[0]) ? 32'(eg) : 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'(m_active));
    endtask

    task automatic model_step();
        int c;
        int l;
        bit found;
        if (!m_active) begin
            if (req != '0) begin
                found = 1'b0;
                for (int o = 0; o < NR; o++) begin
                    if (!found && req[(m_ptr + o) % NR]) begin
                        found = 1'b1;
                        m_win = (m_ptr + o) % NR;
                    end
                end
                c = int'(blink_count[m_win*4 +: 4]);
                l = int'(blink_len[m_win*3 +: 3]);
                if (c == 0) c = 1;
                if (l == 0) l = 1;
                sched_led.delete();
                sched_done.delete();
                for (int b = 0; b < c; b++) begin
                    for (int t = 0; t < l*TD; t++) begin sched_led.push_back(1'b1); sched_done.push_back(1'b0); end
                    for (int t = 0; t < l*TD; t++) begin sched_led.push_back(1'b0); sched_done.push_back(1'b0); end
                end
                blink_left = 2 * c * l * TD;
                for (int g = 0; g < GAP*TD; g++) begin
                    sched_led.push_back(1'b0);
                    sched_done.push_back(g == GAP*TD - 1);
                end
                m_active = 1'b1;
            end
        end else if (blink_left > 0 && !req[m_win]) begin
            sched_led.delete();
            sched_done.delete();
            for (int g = 0; g < GAP*TD; g++) begin sched_led.push_back(1'b0); sched_done.push_back(1'b0); end
            blink_left = 0;
        end else begin
            void'(sched_led.pop_front());
            void'(sched_done.pop_front());
            if (blink_left > 0) blink_left--;
            if (sched_led.size() == 0) begin
                m_active = 1'b0;
                m_ptr    = (m_win + 1) % NR;
            end
        end
    endtask

    // Called at a falling edge: check this cycle, then drive what the next rising edge samples.
    task automatic cycle(input logic [NR-1:0] r, input logic [4*NR-1:0] bc, input logic [3*NR-1:0] bl);
        check_outputs("cyc");
        req         = r;
        blink_count = bc;
        blink_len   = bl;
        model_step();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        @(negedge clk);
        resetn = 1'b1;
    endtask

    logic [NR-1:0]   rr;
    logic [4*NR-1:0] rc;
    logic [3*NR-1:0] rl;

    initial begin
        n_total     = 0;
        n_bad       = 0;
        req         = '0;
        blink_count = '0;
        blink_len   = '0;
        resetn      = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("por");
        resetn = 1'b1;

        // count=2 len=1 on requester 0
        repeat (24) cycle(3'b001, 12'h222, 9'o111);
        repeat (4)  cycle(3'b000, 12'h222, 9'o111);

        // all requesting, count=1: rotation 0,1,2,0
        repeat (70) cycle(3'b111, 12'h111, 9'o111);
        repeat (10) cycle(3'b000, 12'h111, 9'o111);

        // requester 1 aborts mid-ON of a count=5 sequence, then rotation check
        repeat (3)  cycle(3'b010, 12'h555, 9'o111);
        repeat (12) cycle(3'b000, 12'h555, 9'o111);
        repeat (20) cycle(3'b111, 12'h111, 9'o111);
        repeat (12) cycle(3'b000, 12'h111, 9'o111);

        // zero count and len behave as one
        repeat (3)  cycle(3'b001, 12'h000, 9'o000);
        repeat (15) cycle(3'b000, 12'h000, 9'o000);

        // reset mid-OFF, then fresh grant to requester 0
        repeat (6)  cycle(3'b001, 12'h222, 9'o111);
        reset_pulse();
        repeat (10) cycle(3'b001, 12'h222, 9'o111);
        repeat (12) cycle(3'b000, 12'h222, 9'o111);

        // length changes during a held grant are ignored
        cycle(3'b001, 12'h222, 9'o111);
        repeat (23) cycle(3'b001, 12'h222, 9'o777);
        repeat (6)  cycle(3'b000, 12'h222, 9'o777);

        rr = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < NR; b++) begin
                if ($urandom_range(0, 11) == 0) rr[b] = ~rr[b];
            end
            rc = 12'($urandom) & 12'h333;
            rl = 9'($urandom) & 9'o333;
            if ($urandom_range(0, 499) == 0) begin
                reset_pulse();
            end
            cycle(rr, rc, rl);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
